// File: rtl/kb_write_arbiter.sv
// Write-port arbiter between the CPU store path and the keyboard writer.
// Keyboard writes queue in a small FIFO and use idle CPU cycles; a starvation guard forces a one-cycle stall.
module kb_write_arbiter #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     kb_valid,
    input  logic [31:0]              kb_addr,
    input  logic [31:0]              kb_data,
    output logic                     kb_ready,
    input  logic                     cpu_we,
    output logic                     cpu_stall,
    output logic                     mem_we,
    output logic                     mem_we_kb,
    output logic [31:0]              mem_addr_kb,
    output logic [31:0]              mem_data_kb,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     overflow
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned PTRW = AW + 1;
    localparam int unsigned WW   = $clog2(MAX_WAIT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_FORCE = 2'd2
    } state_e;

    state_e            state_q;
    logic [PTRW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTRW-1:0]   pending_d;
    logic [WW-1:0]     wait_cnt_q;
    logic              cpu_stall_q;
    logic              overflow_q;
    logic [31:0]       hold_addr_q, hold_data_q;
    logic [31:0]       fifo_addr_q [DEPTH];
    logic [31:0]       fifo_data_q [DEPTH];

    logic              empty, full, push, pop, blocked, force_go;
    logic [AW-1:0]     wr_idx, rd_idx;

    assign wr_idx    = wr_ptr_q[AW-1:0];
    assign rd_idx    = rd_ptr_q[AW-1:0];
    assign pending   = wr_ptr_q - rd_ptr_q;
    assign empty     = (pending == '0);
    assign full      = (pending == PTRW'(DEPTH));
    assign kb_ready  = ~full;
    assign push      = kb_valid & ~full;
    // A stalled CPU cycle always belongs to the keyboard head.
    assign pop       = ~empty & (~cpu_we | cpu_stall_q);
    assign blocked   = ~empty & cpu_we & ~cpu_stall_q;
    assign force_go  = (state_q == ST_PEND) && blocked && (wait_cnt_q == WW'(MAX_WAIT - 1));
    assign pending_d = pending + PTRW'(push) - PTRW'(pop);

    assign cpu_stall   = cpu_stall_q;
    assign overflow    = overflow_q;
    assign mem_we      = cpu_we & ~cpu_stall_q;
    assign mem_we_kb   = pop;
    assign mem_addr_kb = empty ? hold_addr_q : fifo_addr_q[rd_idx];
    assign mem_data_kb = empty ? hold_data_q : fifo_data_q[rd_idx];

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_idx] <= kb_addr;
            fifo_data_q[wr_idx] <= kb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wait_cnt_q  <= '0;
            cpu_stall_q <= 1'b0;
            overflow_q  <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTRW'(1);
            end
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + PTRW'(1);
                hold_addr_q <= fifo_addr_q[rd_idx];
                hold_data_q <= fifo_data_q[rd_idx];
            end
            if (kb_valid && full) begin
                overflow_q <= 1'b1;
            end

            if (pop || empty) begin
                wait_cnt_q <= '0;
            end else if (blocked && (wait_cnt_q != WW'(MAX_WAIT))) begin
                wait_cnt_q <= wait_cnt_q + WW'(1);
            end

            cpu_stall_q <= force_go;

            unique case (state_q)
                ST_IDLE: begin
                    if (push) state_q <= ST_PEND;
                end
                ST_PEND: begin
                    if (force_go)              state_q <= ST_FORCE;
                    else if (pending_d == '0)  state_q <= ST_IDLE;
                end
                ST_FORCE: begin
                    state_q <= (pending_d != '0) ? ST_PEND : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kb_write_arbiter.sv
// Directed bench for kb_write_arbiter: grant order, starvation stall, overflow, wrap and async reset.
module tb_kb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        kb_valid;
    logic [31:0] kb_addr, kb_data;
    logic        kb_ready;
    logic        cpu_we;
    logic        cpu_stall, mem_we, mem_we_kb;
    logic [31:0] mem_addr_kb, mem_data_kb;
    logic [2:0]  pending;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    kb_write_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .kb_valid    (kb_valid),
        .kb_addr     (kb_addr),
        .kb_data     (kb_data),
        .kb_ready    (kb_ready),
        .cpu_we      (cpu_we),
        .cpu_stall   (cpu_stall),
        .mem_we      (mem_we),
        .mem_we_kb   (mem_we_kb),
        .mem_addr_kb (mem_addr_kb),
        .mem_data_kb (mem_data_kb),
        .pending     (pending),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Leaves the bench 1 time unit after a rising edge; checks follow a further #1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int g;

    initial begin
        rst = 1'b0; kb_valid = 1'b0; kb_addr = '0; kb_data = '0; cpu_we = 1'b0;

        // Reset values
        #3;
        cpu_we = 1'b1;
        #1;
        check("rst_stall",   32'(cpu_stall), 0);
        check("rst_we_kb",   32'(mem_we_kb), 0);
        check("rst_addr",    mem_addr_kb, 0);
        check("rst_data",    mem_data_kb, 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_ovf",     32'(overflow), 0);
        check("rst_ready",   32'(kb_ready), 1);
        check("rst_mem_we1", 32'(mem_we), 1);
        cpu_we = 1'b0;
        #1;
        check("rst_mem_we0", 32'(mem_we), 0);
        tick(); tick();
        rst = 1'b1;

        // Single push with CPU idle: granted the next cycle, hold afterwards
        kb_valid = 1'b1; kb_addr = 32'h10; kb_data = 32'hA5;
        tick();
        kb_valid = 1'b0;
        #1;
        check("t1_pending1", 32'(pending), 1);
        check("t1_grant",    32'(mem_we_kb), 1);
        check("t1_addr",     mem_addr_kb, 32'h10);
        check("t1_data",     mem_data_kb, 32'hA5);
        tick();
        #1;
        check("t1_pending0", 32'(pending), 0);
        check("t1_nogrant",  32'(mem_we_kb), 0);
        check("t1_hold_a",   mem_addr_kb, 32'h10);
        check("t1_hold_d",   mem_data_kb, 32'hA5);

        // CPU priority and forced stall after 8 blocked cycles
        cpu_we = 1'b1; kb_valid = 1'b1; kb_addr = 32'h20; kb_data = 32'h11;
        tick();
        kb_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            #1;
            check("t2_blocked", 32'(mem_we_kb), 0);
            check("t2_nostall", 32'(cpu_stall), 0);
            check("t2_cpu_we",  32'(mem_we), 1);
            tick();
        end
        #1;
        check("t2_stall",   32'(cpu_stall), 1);
        check("t2_mem_we",  32'(mem_we), 0);
        check("t2_grant",   32'(mem_we_kb), 1);
        check("t2_addr",    mem_addr_kb, 32'h20);
        tick();
        #1;
        check("t2_empty",   32'(pending), 0);
        check("t2_unstall", 32'(cpu_stall), 0);
        check("t2_mem_we1", 32'(mem_we), 1);

        // Fill with CPU busy, overflow on the fifth push, then drain in order
        for (int k = 0; k < 4; k++) begin
            kb_valid = 1'b1; kb_addr = 32'h30 + 32'(4 * k); kb_data = 32'hB0 + 32'(k);
            tick();
        end
        kb_addr = 32'h99; kb_data = 32'hEE;
        #1;
        check("t3_full_rdy", 32'(kb_ready), 0);
        check("t3_pend4",    32'(pending), 4);
        check("t3_no_ovf",   32'(overflow), 0);
        tick();
        kb_valid = 1'b0; cpu_we = 1'b0;
        #1;
        check("t3_ovf",      32'(overflow), 1);
        check("t3_pend4b",   32'(pending), 4);
        check("t3_rdy_pop",  32'(kb_ready), 0);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) #1;
            check("t3_grant", 32'(mem_we_kb), 1);
            check("t3_addr",  mem_addr_kb, 32'h30 + 32'(4 * k));
            check("t3_data",  mem_data_kb, 32'hB0 + 32'(k));
            tick();
        end
        #1;
        check("t3_empty",  32'(pending), 0);
        check("t3_hold_a", mem_addr_kb, 32'h3C);
        check("t3_hold_d", mem_data_kb, 32'hB3);
        check("t3_ovf_st", 32'(overflow), 1);
        check("t3_ready",  32'(kb_ready), 1);

        // Simultaneous push and pop at pending=2 across the pointer wrap
        cpu_we = 1'b1; kb_valid = 1'b1; kb_addr = 32'h40; kb_data = 32'hC0;
        tick();
        kb_addr = 32'h44; kb_data = 32'hC1;
        tick();
        cpu_we = 1'b0;
        for (int j = 0; j < 3; j++) begin
            kb_addr = 32'h48 + 32'(4 * j); kb_data = 32'hC2 + 32'(j);
            #1;
            check("t4_pend2", 32'(pending), 2);
            check("t4_grant", 32'(mem_we_kb), 1);
            check("t4_data",  mem_data_kb, 32'hC0 + 32'(j));
            tick();
        end
        kb_valid = 1'b0;
        #1;
        check("t4_pend2e", 32'(pending), 2);
        check("t4_data3",  mem_data_kb, 32'hC3);
        tick();
        #1;
        check("t4_pend1",  32'(pending), 1);
        check("t4_data4",  mem_data_kb, 32'hC4);
        check("t4_addr4",  mem_addr_kb, 32'h50);
        tick();
        #1;
        check("t4_pend0",  32'(pending), 0);

        // Async reset in the middle of a FORCE cycle
        cpu_we = 1'b1; kb_valid = 1'b1; kb_addr = 32'h50; kb_data = 32'hD0;
        tick();
        kb_addr = 32'h54; kb_data = 32'hD1;
        tick();
        kb_valid = 1'b0;
        for (int i = 2; i <= 8; i++) begin
            #1;
            check("t5_nostall", 32'(cpu_stall), 0);
            tick();
        end
        #1;
        check("t5_stall",  32'(cpu_stall), 1);
        check("t5_pend2",  32'(pending), 2);
        #2;
        rst = 1'b0;
        #1;
        check("t5_rst_stall", 32'(cpu_stall), 0);
        check("t5_rst_pend",  32'(pending), 0);
        check("t5_rst_ovf",   32'(overflow), 0);
        check("t5_rst_grant", 32'(mem_we_kb), 0);
        check("t5_rst_we",    32'(mem_we), 1);
        check("t5_rst_ready", 32'(kb_ready), 1);
        tick();
        rst = 1'b1;

        // Intermittent CPU stores: one grant per idle cycle, never a stall
        for (int k = 0; k < 3; k++) begin
            kb_valid = 1'b1; kb_addr = 32'h60 + 32'(4 * k); kb_data = 32'hE0 + 32'(k);
            tick();
        end
        kb_valid = 1'b0;
        g = 0;
        for (int j = 0; j < 5; j++) begin
            cpu_we = (j % 2) == 1;
            #1;
            check("t6_nostall", 32'(cpu_stall), 0);
            if (!cpu_we) begin
                check("t6_grant", 32'(mem_we_kb), 1);
                check("t6_data",  mem_data_kb, 32'hE0 + 32'(g));
                g++;
            end else begin
                check("t6_block", 32'(mem_we_kb), 0);
            end
            tick();
        end
        #1;
        check("t6_empty", 32'(pending), 0);
        check("t6_hold",  mem_addr_kb, 32'h68);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
